// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
//   state_t : FSM encoding (IDLE=0, SHIFT=1, DONE=2)
//   cnt_w() : width of the bit counter, wide enough to hold the value WIDTH
// Optional feature macro used by this block: SERIAL_ADDER_SUB_EN
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter ends at WIDTH after the final shift, so it needs one extra
    // code point beyond WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Operand and result handshake bundle for serial_adder.
//   master : producer/consumer side (drives operands, takes results)
//   slave  : adder side
// Signals:
//   in_valid/in_ready   operand handshake carrying a, b, cin (and sub)
//   out_valid/out_ready result handshake carrying sum, cout
//   busy                adder is shifting or holding a result
// SERIAL_ADDER_SUB_EN defined: adds the 'sub' request bit.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/serial_adder_fa.sv
// -----------------------------------------------------------------------------
// fa
// Combinational 1-bit full adder, the only arithmetic cell of serial_adder.
// Ports:
//   a, b, ci : input bits and carry-in
//   s, co    : sum bit and carry-out
// -----------------------------------------------------------------------------
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder. Operands are taken on an in_valid/in_ready
// handshake, added LSB-first one bit per clock through a single full adder,
// and the result {cout, sum} = a + b + cin is offered on out_valid/out_ready.
// Parameters:
//   WIDTH : operand/sum width in bits (>= 1)
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_if.slave (operand/result handshakes, busy)
// Optional feature: SERIAL_ADDER_SUB_EN adds bus.sub; when set on the
// accepting edge the adder computes a - b (b inverted, carry-in forced to 1)
// and cout=1 means no borrow.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum_shift;

    logic             accept;
    logic             last_shift;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bits enter at the MSB; building the shifted value through a
    // one-bit-wider vector keeps WIDTH=1 legal.
    assign sum_ext   = {fa_s, sum_sr};
    assign sum_shift = sum_ext[WIDTH:1];

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so cin is overridden while sub is set.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub | bus.cin;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        accept      = 1'b0;
        last_shift  = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (cnt == LAST_CNT) begin
                    last_shift = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The visible result (sum_q/cout_q) is only written on the
    // final shift edge, so a partially shifted value is never exposed and
    // the previous result stays put until the next op completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_shift;
            carry  <= fa_co;
            cnt    <= cnt + CNT_W'(1);
            if (last_shift) begin
                sum_q  <= sum_shift;
                cout_q <= fa_co;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed-vector bench for serial_adder (WIDTH=8) with hand-computed
// results. Exercises reset values, add vectors, result hold under
// backpressure, reset mid-shift, ignored in_valid during SHIFT and, when
// SERIAL_ADDER_SUB_EN is defined, subtraction with borrow.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst;

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge while the adder is idle; returns at the
    // falling edge right after the accepting rising edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("[TB] subtract request dropped, feature not built");
`endif
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid is seen, bounded by TIMEOUT.
    task automatic waitResult(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < TIMEOUT) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // Checks the offered result, then consumes it and checks the return to IDLE.
    task automatic takeResult(input string tag, input logic [7:0] expSum,
                              input logic expCout);
        checkOutput({tag, " out_valid"}, bus.out_valid, 1);
        checkOutput({tag, " sum"}, bus.sum, expSum);
        checkOutput({tag, " cout"}, bus.cout, expCout);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, " out_valid after take"}, bus.out_valid, 0);
        checkOutput({tag, " in_ready after take"}, bus.in_ready, 1);
    endtask

    initial begin
        int lat;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        checkOutput("reset in_ready", bus.in_ready, 1);
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset sum", bus.sum, 0);
        checkOutput("reset cout", bus.cout, 0);

        // 3C + 0F: result after exactly WIDTH edges
        applyStimulus(8'h3C, 8'h0F, 1'b0, 1'b0);
        checkOutput("t1 busy", bus.busy, 1);
        checkOutput("t1 in_ready", bus.in_ready, 0);
        waitResult(lat);
        checkOutput("t1 latency", lat, WIDTH);
        takeResult("t1", 8'h4B, 1'b0);

        // FF + 01 + 1 ripples the carry through every bit
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        waitResult(lat);
        takeResult("t2", 8'h01, 1'b1);

        // Backpressure: result must hold while out_ready stays low
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        waitResult(lat);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3 hold out_valid", bus.out_valid, 1);
            checkOutput("t3 hold sum", bus.sum, 8'h46);
            checkOutput("t3 hold cout", bus.cout, 0);
            @(negedge clk);
        end
        takeResult("t3", 8'h46, 1'b0);

        // Reset after the third shift edge abandons the op
        applyStimulus(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("t4 busy mid-shift", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t4 in_ready", bus.in_ready, 1);
        checkOutput("t4 out_valid", bus.out_valid, 0);
        checkOutput("t4 busy", bus.busy, 0);
        checkOutput("t4 sum", bus.sum, 0);
        checkOutput("t4 cout", bus.cout, 0);

        // in_valid and out_ready during SHIFT must have no effect
        applyStimulus(8'hC8, 8'h64, 1'b0, 1'b0);
        @(negedge clk);
        bus.a         = 8'hAA;
        bus.b         = 8'hAA;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        checkOutput("t5 in_ready during shift", bus.in_ready, 0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("t5 still busy", bus.busy, 1);
        waitResult(lat);
        takeResult("t5", 8'h2C, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("t5 no phantom op", bus.busy, 0);
        checkOutput("t5 sum kept in idle", bus.sum, 8'h2C);

        // All ones plus carry-in
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
        waitResult(lat);
        takeResult("t6", 8'hFF, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction with and without borrow; cin must be ignored
        applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
        waitResult(lat);
        takeResult("t7 borrow", 8'hFE, 1'b0);
        applyStimulus(8'h07, 8'h05, 1'b0, 1'b1);
        waitResult(lat);
        takeResult("t7 no borrow", 8'h02, 1'b1);
        bus.sub = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
